hwpe_ctrl_job_queue: RTL and testbench

//  Multi-context job dispatcher for HWPE accelerators; parametrised successor of the single-FSM control slave.

---
 rtl/hwpe_ctrl_job_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_hwpe_ctrl_job_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_job_queue.sv
// Multi-context HWPE job dispatcher: cores lock, program and trigger slots that run
// in FIFO order; completion is signalled to the offloading core only.
module hwpe_ctrl_job_queue #(
   parameter int unsigned N_CORES      = 8,
   parameter int unsigned N_CONTEXT    = 4,
   parameter int unsigned ID_WIDTH     = 8,
   parameter int unsigned JOB_ID_W     = 8,
   parameter int unsigned CLEAR_CYCLES = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   output logic                         clear_o,
   input  logic                         req_i,
   output logic                         gnt_o,
   input  logic [31:0]                  add_i,
   input  logic                         wen_i,
   input  logic [31:0]                  data_i,
   input  logic [ID_WIDTH-1:0]          id_i,
   output logic [31:0]                  r_data_o,
   output logic                         r_valid_o,
   output logic [ID_WIDTH-1:0]          r_id_o,
   output logic [$clog2(N_CONTEXT)-1:0] wptr_o,
   output logic [$clog2(N_CONTEXT)-1:0] rptr_o,
   output logic                         start_o,
   output logic                         busy_o,
   input  logic                         done_i,
   output logic [N_CORES-1:0]           evt_o
);

   localparam int unsigned PW  = $clog2(N_CONTEXT);
   localparam int unsigned PNW = PW + 1;
   localparam int unsigned CW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned CCW = $clog2(CLEAR_CYCLES + 1);

   localparam logic [2:0] OFF_TRIGGER    = 3'd0;
   localparam logic [2:0] OFF_ACQUIRE    = 3'd1;
   localparam logic [2:0] OFF_FINISHED   = 3'd2;
   localparam logic [2:0] OFF_STATUS     = 3'd3;
   localparam logic [2:0] OFF_RUNNING    = 3'd4;
   localparam logic [2:0] OFF_SOFT_CLEAR = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [PNW-1:0]        pending_q, pending_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [JOB_ID_W-1:0]   job_id_q, job_id_d;
   logic [31:0]           finished_q, finished_d;
   logic                  lock_q, lock_d;
   logic [ID_WIDTH-1:0]   owner_q, owner_d;
   logic [CW-1:0]         slot_core_q [N_CONTEXT];
   logic [JOB_ID_W-1:0]   slot_job_q  [N_CONTEXT];
   logic [N_CORES-1:0]    evt_q, evt_d;
   logic [CCW-1:0]        clear_cnt_q, clear_cnt_d;
   logic                  r_valid_q;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [31:0]           r_data_q, r_data_d;

   logic                  rd, wr;
   logic [2:0]            off;
   logic                  soft_clr, flush;
   logic                  is_owner, full;
   logic                  acq_ok, trig_ok, done_ok;
   logic                  unused_bits;

   function automatic logic [CW-1:0] lowest_core(input logic [ID_WIDTH-1:0] oh);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         if (oh[i]) idx = CW'(i);
      end
      return idx;
   endfunction

   assign unused_bits = ^{data_i, add_i[31:5], add_i[1:0]};

   assign rd       = req_i & wen_i;
   assign wr       = req_i & ~wen_i;
   assign off      = add_i[4:2];
   assign clear_o  = (clear_cnt_q != '0);
   // A clear request resets state on the following edge; clear_o then holds it there.
   assign soft_clr = wr && (off == OFF_SOFT_CLEAR) && !clear_o;
   assign flush    = clear_o | soft_clr;
   assign is_owner = lock_q && (id_i == owner_q);
   assign full     = (pending_q == PNW'(N_CONTEXT));
   assign acq_ok   = rd && (off == OFF_ACQUIRE) && !clear_o && !lock_q && !full;
   assign trig_ok  = wr && (off == OFF_TRIGGER) && !clear_o && is_owner;
   assign done_ok  = (state_q == RUN) && done_i;

   assign gnt_o     = 1'b1;
   assign r_valid_o = r_valid_q;
   assign r_id_o    = r_id_q;
   assign r_data_o  = r_data_q;
   assign wptr_o    = wptr_q;
   assign rptr_o    = rptr_q;
   assign evt_o     = evt_q;

   // Dispatch FSM
   always_comb begin
      state_d = state_q;
      start_o = 1'b0;
      busy_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q != '0) state_d = START;
         end
         START: begin
            start_o = 1'b1;
            busy_o  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            busy_o = 1'b1;
            if (done_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      pending_d   = pending_q + PNW'(trig_ok) - PNW'(done_ok);
      wptr_d      = wptr_q + PW'(trig_ok);
      rptr_d      = rptr_q + PW'(done_ok);
      job_id_d    = job_id_q + JOB_ID_W'(trig_ok);
      finished_d  = finished_q + 32'(done_ok);
      lock_d      = lock_q;
      owner_d     = owner_q;
      evt_d       = '0;
      clear_cnt_d = clear_cnt_q;

      if (acq_ok) begin
         lock_d  = 1'b1;
         owner_d = id_i;
      end
      if (trig_ok) lock_d = 1'b0;
      if (done_ok) evt_d[slot_core_q[rptr_q]] = 1'b1;

      if (soft_clr)            clear_cnt_d = CCW'(CLEAR_CYCLES);
      else if (clear_cnt_q != '0) clear_cnt_d = clear_cnt_q - 1'b1;

      if (flush) begin
         pending_d  = '0;
         wptr_d     = '0;
         rptr_d     = '0;
         job_id_d   = '0;
         finished_d = '0;
         lock_d     = 1'b0;
         owner_d    = '0;
         evt_d      = '0;
      end
   end

   // Register read mux; reads during clear answer with zero data
   always_comb begin
      r_id_d   = req_i ? id_i : '0;
      r_data_d = '0;
      if (rd && !clear_o) begin
         case (off)
            OFF_ACQUIRE:  r_data_d = ((!lock_q && !full) || is_owner) ? 32'(job_id_q) : 32'hFFFF_FFFF;
            OFF_FINISHED: r_data_d = finished_q;
            OFF_STATUS:   r_data_d = {16'(pending_q), 8'(lock_q), 7'b0, busy_o};
            OFF_RUNNING:  r_data_d = busy_o ? 32'(slot_job_q[rptr_q]) : 32'hFFFF_FFFF;
            default:      r_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         job_id_q    <= '0;
         finished_q  <= '0;
         lock_q      <= 1'b0;
         owner_q     <= '0;
         evt_q       <= '0;
         clear_cnt_q <= '0;
         r_valid_q   <= 1'b0;
         r_id_q      <= '0;
         r_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         job_id_q    <= job_id_d;
         finished_q  <= finished_d;
         lock_q      <= lock_d;
         owner_q     <= owner_d;
         evt_q       <= evt_d;
         clear_cnt_q <= clear_cnt_d;
         r_valid_q   <= req_i;
         r_id_q      <= r_id_d;
         r_data_q    <= r_data_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            slot_core_q[i] <= '0;
            slot_job_q[i]  <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            slot_core_q[i] <= '0;
            slot_job_q[i]  <= '0;
         end
      end else if (trig_ok) begin
         slot_core_q[wptr_q] <= lowest_core(owner_q);
         slot_job_q[wptr_q]  <= job_id_q;
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// Bench for hwpe_ctrl_job_queue: directed scenarios plus randomized traffic checked
// against a queue-based transaction model.
module tb_hwpe_ctrl_job_queue;

   localparam int NCTX = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] add = '0;
   logic        wen = 1'b0;
   logic [31:0] wdata = '0;
   logic [7:0]  id_in = '0;
   logic [31:0] r_data;
   logic        r_valid;
   logic [7:0]  r_id;
   logic [1:0]  wptr, rptr;
   logic        start, busy;
   logic        done = 1'b0;
   logic [7:0]  evt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int core;
      int job;
   } job_t;

   job_t       m_q[$];
   int         m_next, m_finished, m_ntrig, m_ndone;
   bit         m_lock;
   logic [7:0] m_owner;

   hwpe_ctrl_job_queue dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_o   (clear),
      .req_i     (req),
      .gnt_o     (gnt),
      .add_i     (add),
      .wen_i     (wen),
      .data_i    (wdata),
      .id_i      (id_in),
      .r_data_o  (r_data),
      .r_valid_o (r_valid),
      .r_id_o    (r_id),
      .wptr_o    (wptr),
      .rptr_o    (rptr),
      .start_o   (start),
      .busy_o    (busy),
      .done_i    (done),
      .evt_o     (evt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_next = 0; m_finished = 0; m_ntrig = 0; m_ndone = 0;
      m_lock = 1'b0; m_owner = '0;
   endtask

   function automatic int core_of(input logic [7:0] oh);
      int c;
      c = -1;
      for (int i = 0; i < 8; i++) if (oh == (8'd1 << i)) c = i;
      return c;
   endfunction

   function automatic logic [31:0] m_acquire(input logic [7:0] id);
      if (m_lock) return (id == m_owner) ? 32'(m_next) : 32'hFFFF_FFFF;
      if (m_q.size() >= NCTX) return 32'hFFFF_FFFF;
      m_lock = 1'b1;
      m_owner = id;
      return 32'(m_next);
   endfunction

   task automatic m_trigger(input logic [7:0] id);
      job_t j;
      if (m_lock && id == m_owner) begin
         j.core = core_of(id);
         j.job  = m_next;
         m_q.push_back(j);
         m_next = (m_next + 1) % 256;
         m_lock = 1'b0;
         m_ntrig++;
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_rd(input int off, input logic [7:0] id, output logic [31:0] d);
      @(negedge clk);
      req = 1'b1; wen = 1'b1; add = 32'(off) << 2; id_in = id;
      @(posedge clk); #1;
      chk("r_valid", 32'(r_valid), 32'd1);
      chk("r_id", 32'(r_id), 32'(id));
      d = r_data;
      req = 1'b0; wen = 1'b0; id_in = '0;
   endtask

   task automatic bus_wr(input int off, input logic [7:0] id, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; wen = 1'b0; add = 32'(off) << 2; id_in = id; wdata = d;
      @(posedge clk); #1;
      req = 1'b0; id_in = '0;
   endtask

   task automatic op_acquire(input logic [7:0] id, output logic [31:0] d);
      logic [31:0] exp;
      exp = m_acquire(id);
      bus_rd(1, id, d);
      chk("acquire", d, exp);
   endtask

   task automatic op_trigger(input logic [7:0] id);
      m_trigger(id);
      bus_wr(0, id, $urandom);
   endtask

   task automatic op_status();
      logic [31:0] d, exp;
      exp = {16'(m_q.size()), 7'b0, m_lock, 7'b0, (m_q.size() != 0)};
      bus_rd(3, 8'h01, d);
      chk("status", d, exp);
   endtask

   task automatic op_finished();
      logic [31:0] d;
      bus_rd(2, 8'h02, d);
      chk("finished", d, 32'(m_finished));
   endtask

   task automatic op_running();
      logic [31:0] d, exp;
      exp = (m_q.size() != 0) ? 32'(m_q[0].job) : 32'hFFFF_FFFF;
      bus_rd(4, 8'h04, d);
      chk("running_job", d, exp);
   endtask

   task automatic op_done();
      logic [7:0] exp;
      exp = '0;
      exp[m_q[0].core] = 1'b1;
      void'(m_q.pop_front());
      m_finished++;
      m_ndone++;
      @(negedge clk); done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      chk("evt", 32'(evt), 32'(exp));
      @(posedge clk); #1;
      chk("evt_pulse_end", 32'(evt), 32'd0);
   endtask

   task automatic op_spurious_done();
      @(negedge clk); done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      chk("evt_spurious", 32'(evt), 32'd0);
   endtask

   task automatic chk_ptrs();
      chk("wptr", 32'(wptr), 32'(m_ntrig % NCTX));
      chk("rptr", 32'(rptr), 32'(m_ndone % NCTX));
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  cid;
      job_t        j;
      m_reset();

      // Reset values
      #12;
      chk("rst_gnt", 32'(gnt), 32'd1);
      chk("rst_evt", 32'(evt), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clear", 32'(clear), 32'd0);
      chk("rst_rvalid", 32'(r_valid), 32'd0);
      chk("rst_rdata", r_data, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      gap(1);
      op_status();
      chk("status_zero", r_data, 32'd0);
      chk_ptrs();

      // Single job from core 2
      op_acquire(8'b0000_0100, d);
      chk("acq_first", d, 32'd0);
      gap(3);
      op_trigger(8'b0000_0100);
      chk("start_t1", 32'(start), 32'd0);
      @(posedge clk); #1;
      chk("start_t2", 32'(start), 32'd1);
      chk("busy_t2", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("start_t3", 32'(start), 32'd0);
      chk("busy_t3", 32'(busy), 32'd1);
      op_running();
      op_done();
      chk("evt_core2_model", 32'(m_finished), 32'd1);
      gap(3);
      op_finished();
      chk("finished_one", r_data, 32'd1);
      chk_ptrs();

      // Async reset while a job runs
      op_acquire(8'h01, d);
      op_trigger(8'h01);
      gap(3);
      chk("busy_before_rst", 32'(busy), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_wptr", 32'(wptr), 32'd0);
      chk("arst_evt", 32'(evt), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      gap(2);
      chk("arst_evt_after", 32'(evt), 32'd0);
      op_status();

      // Fill all contexts with the engine stalled
      for (int k = 0; k < 4; k++) begin
         op_acquire(8'(1 << k), d);
         chk("acq_fill", d, 32'(k));
         op_trigger(8'(1 << k));
         gap(3);
      end
      op_acquire(8'h10, d);
      chk("acq_full", d, 32'hFFFF_FFFF);
      chk("wptr_wrapped", 32'(wptr), 32'd0);
      op_status();
      op_done();
      gap(3);
      op_acquire(8'h10, d);
      chk("acq_after_done", d, 32'd4);
      op_trigger(8'h10);
      gap(3);
      chk_ptrs();
      while (m_q.size() > 0) begin
         op_running();
         op_done();
         gap(3);
      end
      op_finished();

      // Lock ownership
      op_acquire(8'b0000_0010, d);
      op_acquire(8'b0000_1000, d);
      chk("acq_locked", d, 32'hFFFF_FFFF);
      op_trigger(8'b0000_1000);
      gap(3);
      op_status();
      chk("nonowner_ignored", r_data[31:16], 32'd0);
      op_acquire(8'b0000_0010, d);
      chk("owner_reread", d, 32'(m_next));
      op_trigger(8'b0000_0010);
      gap(3);
      op_status();
      chk_ptrs();

      // TRIGGER coincident with done, pending = 2
      op_acquire(8'h20, d);
      op_trigger(8'h20);
      gap(3);
      op_status();
      chk("pending_two", r_data[31:16], 32'd2);
      op_acquire(8'h40, d);
      gap(3);
      cid = '0;
      cid[m_q[0].core] = 1'b1;
      void'(m_q.pop_front());
      m_finished++; m_ndone++;
      m_trigger(8'h40);
      @(negedge clk);
      req = 1'b1; wen = 1'b0; add = 32'd0; id_in = 8'h40; done = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; id_in = '0; done = 1'b0;
      chk("coinc_evt", 32'(evt), 32'(cid));
      chk("coinc_start_t1", 32'(start), 32'd0);
      chk_ptrs();
      @(posedge clk); #1;
      chk("coinc_start_t2", 32'(start), 32'd1);
      gap(3);
      op_status();
      chk("coinc_pending", r_data[31:16], 32'd2);
      while (m_q.size() > 0) begin
         op_done();
         gap(3);
      end

      // Soft clear in the middle of a run
      op_acquire(8'h80, d);
      op_trigger(8'h80);
      gap(3);
      chk("busy_before_clear", 32'(busy), 32'd1);
      bus_wr(5, 8'h80, $urandom);
      m_reset();
      chk("clear_c1", 32'(clear), 32'd1);
      chk("clear_busy", 32'(busy), 32'd0);
      bus_rd(3, 8'h01, d);
      chk("clear_status", d, 32'd0);
      chk("clear_c2", 32'(clear), 32'd1);
      @(negedge clk); done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      chk("clear_end", 32'(clear), 32'd0);
      chk("late_done_evt", 32'(evt), 32'd0);
      gap(1);
      chk("late_done_evt2", 32'(evt), 32'd0);
      op_acquire(8'h08, d);
      chk("acq_after_clear", d, 32'd0);
      op_status();
      chk_ptrs();

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         cid = 8'd1 << $urandom_range(0, 7);
         if (m_lock && $urandom_range(0, 1) == 1) cid = m_owner;
         case ($urandom_range(0, 9))
            0, 1, 2: op_acquire(cid, d);
            3, 4:    op_trigger(cid);
            5: begin
               if (m_q.size() > 0) op_done();
               else op_spurious_done();
            end
            6: op_status();
            7: op_finished();
            8: op_running();
            default: begin
               if ($urandom_range(0, 1) == 1) begin
                  bus_rd($urandom_range(6, 7), cid, d);
                  chk("unmapped_rd", d, 32'd0);
               end else begin
                  bus_wr($urandom_range(6, 7), cid, $urandom);
               end
            end
         endcase
         gap(3);
         chk_ptrs();
      end
      op_status();
      op_finished();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
